// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply operand sequencer.
//   - state_t       : sequencer state encoding (LOAD, CLEAR, FEED, DRAIN, DONE)
//   - MATMUL_*      : default matrix dimension, operand width, lane width, drain length
//   - BYTES_PER_JOB : operand bytes per job (A then B, both N*N, row-major)
//   - clog2_min1    : $clog2 that never returns a zero width
package matmul_pkg;

  localparam int MATMUL_N            = 4;
  localparam int MATMUL_DATA_W       = 8;
  localparam int MATMUL_LANE_W       = 32;
  localparam int MATMUL_DRAIN_CYCLES = 4;
  localparam int BYTES_PER_JOB       = 2 * MATMUL_N * MATMUL_N;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/matmul_skew_feed.sv
// Combinational skew selector for a systolic array feed.
//   a_flat  : A operands, row-major, element (r,c) at [(r*N+c)*DATA_W +: DATA_W]
//   b_flat  : B operands, row-major, same layout
//   t       : feed step (0 .. 2N-2)
//   a_lanes : lane i = A[i][t-i] zero-extended, or 0 when t-i is outside 0..N-1
//   b_lanes : lane j = B[t-j][j] zero-extended, or 0 when t-j is outside 0..N-1
module matmul_skew_feed
  import matmul_pkg::*;
#(
  parameter int N      = MATMUL_N,
  parameter int DATA_W = MATMUL_DATA_W,
  parameter int LANE_W = MATMUL_LANE_W,
  parameter int T_W    = 3
) (
  input  logic [N*N*DATA_W-1:0] a_flat,
  input  logic [N*N*DATA_W-1:0] b_flat,
  input  logic [T_W-1:0]        t,
  output logic [N*LANE_W-1:0]   a_lanes,
  output logic [N*LANE_W-1:0]   b_lanes
);

  // Lane i of A and lane i of B share the same diagonal offset t-i, so a
  // single range test gates both selections.
  always_comb begin
    a_lanes = '0;
    b_lanes = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(t) >= i) && ((int'(t) - i) < N)) begin
        a_lanes[i*LANE_W +: LANE_W] =
          LANE_W'(a_flat[(i*N + int'(t) - i)*DATA_W +: DATA_W]);
        b_lanes[i*LANE_W +: LANE_W] =
          LANE_W'(b_flat[((int'(t) - i)*N + i)*DATA_W +: DATA_W]);
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Operand loader and skewed feed sequencer for an N x N systolic multiplier.
// Collects 2*N*N operand bytes (A then B, row-major), pulses o_clear, streams
// skewed A/B lanes for 2N-1 cycles, waits DRAIN_CYCLES, then pulses o_done.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_data, i_data_valid : operand byte and its single-cycle strobe
//   o_a, o_b         : registered skewed lanes (LANE_W each, lane i at [LANE_W*i +: LANE_W])
//   o_clear          : one-cycle accumulator clear before feeding
//   o_feed           : high while o_a/o_b carry valid operands
//   o_done           : one-cycle pulse, array results stable
//   o_busy           : high in every state except LOAD
//   o_load_count     : bytes stored so far in the current job
//   o_overrun        : sticky, a byte arrived outside LOAD (cleared only by reset)
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N            = MATMUL_N,
  parameter int DATA_W       = MATMUL_DATA_W,
  parameter int LANE_W       = MATMUL_LANE_W,
  parameter int DRAIN_CYCLES = MATMUL_DRAIN_CYCLES
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_data_valid,
  output logic [N*LANE_W-1:0]          o_a,
  output logic [N*LANE_W-1:0]          o_b,
  output logic                         o_clear,
  output logic                         o_feed,
  output logic                         o_done,
  output logic                         o_busy,
  output logic [$clog2(2*N*N):0]       o_load_count,
  output logic                         o_overrun
);

  localparam int BYTES  = 2 * N * N;
  localparam int CNT_W  = $clog2(BYTES) + 1;
  localparam int ADDR_W = clog2_min1(BYTES);
  localparam int T_W    = clog2_min1(2 * N);
  localparam int DC_W   = clog2_min1(DRAIN_CYCLES);

  localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(BYTES - 1);
  localparam logic [T_W-1:0]   LAST_T      = T_W'(2 * N - 2);
  localparam logic [DC_W-1:0]  LAST_DRAIN  = DC_W'(DRAIN_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    load_count;
  logic [T_W-1:0]      t;
  logic [DC_W-1:0]     drain_cnt;

  logic [DATA_W-1:0]     store [BYTES];
  logic [N*N*DATA_W-1:0] a_flat;
  logic [N*N*DATA_W-1:0] b_flat;
  logic [T_W-1:0]        t_sel_p0;
  logic [N*LANE_W-1:0]   a_lanes_p0;
  logic [N*LANE_W-1:0]   b_lanes_p0;
  logic                  accept;

  assign accept       = (state == ST_LOAD) && i_data_valid;
  assign o_load_count = load_count;

  // Operand store: written only by accepted LOAD bytes, never reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      store[load_count[ADDR_W-1:0]] <= i_data;
    end
  end

  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int k = 0; k < N*N; k++) begin
      a_flat[k*DATA_W +: DATA_W] = store[k];
      b_flat[k*DATA_W +: DATA_W] = store[N*N + k];
    end
  end

  // ---- stage p0: lane selection for the step the registers load next ----
  // Leaving CLEAR loads step 0; inside FEED the registers load step t+1.
  assign t_sel_p0 = (state == ST_FEED) ? (t + T_W'(1)) : '0;

  matmul_skew_feed #(
    .N      (N),
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .T_W    (T_W)
  ) u_skew (
    .a_flat  (a_flat),
    .b_flat  (b_flat),
    .t       (t_sel_p0),
    .a_lanes (a_lanes_p0),
    .b_lanes (b_lanes_p0)
  );

  // ---- stage p1: sequencer state and registered outputs ----
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_LOAD;
      load_count <= '0;
      t          <= '0;
      drain_cnt  <= '0;
      o_a        <= '0;
      o_b        <= '0;
      o_clear    <= 1'b0;
      o_feed     <= 1'b0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_clear <= 1'b0;
      o_done  <= 1'b0;

      if (i_data_valid && (state != ST_LOAD)) begin
        o_overrun <= 1'b1;
      end

      case (state)
        ST_LOAD: begin
          if (i_data_valid) begin
            load_count <= load_count + CNT_W'(1);
            if (load_count == LAST_BYTE) begin
              state   <= ST_CLEAR;
              o_clear <= 1'b1;
              o_busy  <= 1'b1;
            end
          end
        end

        ST_CLEAR: begin
          state  <= ST_FEED;
          t      <= '0;
          o_feed <= 1'b1;
          o_a    <= a_lanes_p0;
          o_b    <= b_lanes_p0;
        end

        ST_FEED: begin
          if (t == LAST_T) begin
            o_feed    <= 1'b0;
            o_a       <= '0;
            o_b       <= '0;
            drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            t   <= t + T_W'(1);
            o_a <= a_lanes_p0;
            o_b <= b_lanes_p0;
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end

        ST_DONE: begin
          state      <= ST_LOAD;
          load_count <= '0;
          o_busy     <= 1'b0;
        end

        default: begin
          state      <= ST_LOAD;
          load_count <= '0;
          o_feed     <= 1'b0;
          o_a        <= '0;
          o_b        <= '0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: a job-timeline model of the
// expected outputs, checked every cycle, plus literal checks on chosen jobs.
module tb_matmul_sequencer;

  localparam int NN      = 4;
  localparam int DW      = 8;
  localparam int LW      = 32;
  localparam int DR      = 4;
  localparam int BYTES   = 2 * NN * NN;
  localparam int FEED_FIRST = 2;
  localparam int FEED_LAST  = 2 * NN;
  localparam int DONE_PH    = 2 * NN + 1 + DR;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     data = '0;
  logic              valid = 1'b0;
  logic [NN*LW-1:0]  o_a;
  logic [NN*LW-1:0]  o_b;
  logic              o_clear;
  logic              o_feed;
  logic              o_done;
  logic              o_busy;
  logic [$clog2(BYTES):0] o_load_count;
  logic              o_overrun;

  int tests = 0;
  int fails = 0;
  int job_kind = 0;
  logic [7:0] job_bytes [BYTES];

  // Model: m_phase = -1 while loading, otherwise clock edges since the last
  // byte of the job was accepted (1 = CLEAR, 2..2N = FEED, then DRAIN, DONE).
  int         m_phase = -1;
  int         m_cnt = 0;
  bit         m_ovr = 1'b0;
  logic [7:0] m_mem [BYTES];

  always #5 clk = ~clk;

  matmul_sequencer #(
    .N            (NN),
    .DATA_W       (DW),
    .LANE_W       (LW),
    .DRAIN_CYCLES (DR)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_data       (data),
    .i_data_valid (valid),
    .o_a          (o_a),
    .o_b          (o_b),
    .o_clear      (o_clear),
    .o_feed       (o_feed),
    .o_done       (o_done),
    .o_busy       (o_busy),
    .o_load_count (o_load_count),
    .o_overrun    (o_overrun)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= -1;
      m_cnt   <= 0;
      m_ovr   <= 1'b0;
    end else if (m_phase < 0) begin
      if (valid) begin
        m_mem[m_cnt] <= data;
        m_cnt        <= m_cnt + 1;
        if (m_cnt == BYTES - 1) m_phase <= 1;
      end
    end else begin
      if (valid) m_ovr <= 1'b1;
      if (m_phase == DONE_PH) begin
        m_phase <= -1;
        m_cnt   <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  function automatic logic [127:0] exp_a();
    logic [127:0] r;
    int t;
    r = '0;
    t = m_phase - 2;
    if (m_phase >= FEED_FIRST && m_phase <= FEED_LAST)
      for (int i = 0; i < NN; i++)
        if (t - i >= 0 && t - i < NN) r[i*LW +: LW] = {24'd0, m_mem[i*NN + t - i]};
    return r;
  endfunction

  function automatic logic [127:0] exp_b();
    logic [127:0] r;
    int t;
    r = '0;
    t = m_phase - 2;
    if (m_phase >= FEED_FIRST && m_phase <= FEED_LAST)
      for (int j = 0; j < NN; j++)
        if (t - j >= 0 && t - j < NN) r[j*LW +: LW] = {24'd0, m_mem[NN*NN + (t - j)*NN + j]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("clear",      128'(o_clear),      128'(m_phase == 1));
    chk("feed",       128'(o_feed),       128'(m_phase >= FEED_FIRST && m_phase <= FEED_LAST));
    chk("done",       128'(o_done),       128'(m_phase == DONE_PH));
    chk("busy",       128'(o_busy),       128'(m_phase >= 1));
    chk("load_count", 128'(o_load_count), 128'(m_cnt));
    chk("overrun",    128'(o_overrun),    128'(m_ovr));
    chk("o_a",        o_a,                exp_a());
    chk("o_b",        o_b,                exp_b());

    if (!rst_n) begin
      chk("lit_rst_a",    o_a,              128'd0);
      chk("lit_rst_feed", 128'(o_feed),     128'd0);
    end

    case (job_kind)
      1: begin
        if (m_phase == 1) chk("lit_id_clear", 128'(o_clear), 128'd1);
        if (m_phase == 2) begin
          chk("lit_id_a_t0", o_a, 128'd1);
          chk("lit_id_b_t0", o_b, 128'd1);
        end
        if (m_phase == 5) begin
          chk("lit_id_a_t3", o_a, 128'd0);
          chk("lit_id_b_t3", o_b, {32'd4, 32'd7, 32'd10, 32'd13});
        end
        if (m_phase == 8) begin
          chk("lit_id_a_t6", o_a, {32'd1, 96'd0});
          chk("lit_id_b_t6", o_b, {32'd16, 96'd0});
        end
        if (m_phase == 13) chk("lit_id_done13", 128'(o_done), 128'd1);
      end
      2: begin
        if (m_phase == 5) begin
          chk("lit_ff_a_t3", o_a, {4{32'h000000FF}});
          chk("lit_ff_b_t3", o_b, {4{32'h000000FF}});
        end
        if (m_phase == 8) begin
          chk("lit_ff_a_t6", o_a, {32'hFF, 96'd0});
          chk("lit_ff_b_t6", o_b, {32'hFF, 96'd0});
        end
        if (m_phase >= 9 && m_phase <= 12) begin
          chk("lit_ff_a_drain", o_a, 128'd0);
          chk("lit_ff_b_drain", o_b, 128'd0);
        end
      end
      4: begin
        if (m_phase == 5) begin
          chk("lit_ovr_sticky", 128'(o_overrun), 128'd1);
          chk("lit_ovr_a_t3",   o_a, {32'd13, 32'd10, 32'd7, 32'd4});
        end
      end
      6: begin
        if (m_phase == 5) chk("lit_post_rst_ovr", 128'(o_overrun), 128'd0);
        if (m_phase == 13) chk("lit_post_rst_done", 128'(o_done), 128'd1);
      end
      default: ;
    endcase
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the 32 job bytes; gap > 0 inserts one idle cycle after every gap bytes.
  // Returns at the negedge inside the CLEAR cycle.
  task automatic send_job(input int gap);
    for (int k = 0; k < BYTES; k++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = job_bytes[k];
      if (gap > 0 && (k % gap) == gap - 1 && k != BYTES - 1) begin
        @(negedge clk);
        valid = 1'b0;
      end
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    wait_neg(3);
    rst_n = 1'b1;

    // Identity A, B = 1..16.
    for (int k = 0; k < NN*NN; k++) begin
      job_bytes[k]         = 8'(((k / NN) == (k % NN)) ? 1 : 0);
      job_bytes[NN*NN + k] = 8'(k + 1);
    end
    job_kind = 1;
    send_job(0);
    wait_neg(13);

    // All 0xFF.
    for (int k = 0; k < BYTES; k++) job_bytes[k] = 8'hFF;
    job_kind = 2;
    send_job(0);
    wait_neg(13);

    // Overrun strobes in FEED and in DONE, then a clean job.
    for (int k = 0; k < BYTES; k++) job_bytes[k] = 8'(k * 7 + 3);
    job_kind = 3;
    send_job(0);
    wait_neg(3);
    valid = 1'b1;
    data  = 8'hAA;
    @(negedge clk);
    valid = 1'b0;
    wait_neg(8);
    valid = 1'b1;
    data  = 8'hBB;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < BYTES; k++) job_bytes[k] = 8'(k + 1);
    job_kind = 4;
    send_job(0);
    wait_neg(13);

    // Reset in FEED at t=2, then a job with idle gaps.
    for (int k = 0; k < BYTES; k++) job_bytes[k] = 8'(255 - k);
    job_kind = 5;
    send_job(0);
    wait_neg(2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < BYTES; k++) job_bytes[k] = 8'(k * 5);
    job_kind = 6;
    send_job(5);
    wait_neg(13);

    // Back-to-back consecutive job.
    for (int k = 0; k < BYTES; k++) job_bytes[k] = 8'(k) ^ 8'h5A;
    job_kind = 7;
    send_job(0);
    wait_neg(16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
